// File: rtl/bitblade_pkg.sv
// bitblade_pkg: shared mode encodings, hold-length helper and fetch FSM states
package bitblade_pkg;
  localparam logic [1:0] MODE_8B = 2'b00;
  localparam logic [1:0] MODE_4B = 2'b01;
  localparam logic [1:0] MODE_2B = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ALIGN, S_STREAM, S_FLUSH, S_DONE
  } fetch_state_t;
  function automatic logic [2:0] hold_cycles(input logic [1:0] mode);
    return mode == MODE_8B ? 3'd1 : mode == MODE_4B ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mux_phase_tracker.sv
// mux_phase_tracker: mirrors the free-running slice state of Input_MUX_REG
module mux_phase_tracker
  import bitblade_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] weight_bitwidth,
  output logic [1:0] phase,
  output logic       last_phase
);
  logic [1:0] r_phase;
  logic [2:0] w_hold;
  assign w_hold = hold_cycles(weight_bitwidth);
  assign phase = r_phase;
  // 8-bit mode holds phase at any value, so every cycle ends a word there
  assign last_phase = w_hold == 3'd1 || {1'b0, r_phase} == w_hold - 3'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_phase <= '0;
    else r_phase <= weight_bitwidth == MODE_8B ? r_phase :
                    (weight_bitwidth == MODE_4B && r_phase == 2'd1) ? 2'd0 : r_phase + 2'd1;
endmodule

// File: rtl/input_buffer_fetch.sv
// input_buffer_fetch: streams SRAM words to Input_MUX_REG, each held for one full slice cycle
module input_buffer_fetch
  import bitblade_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [1:0]        weight_bitwidth,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       buffer_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);
  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num, r_rd_cnt, r_wr_cnt;
  logic              r_rd_pend, r_valid;
  logic [31:0]       r_buf;
  logic [1:0]        w_phase;
  logic [2:0]        w_hold;
  logic              w_last, w_align, w_rd;
  mux_phase_tracker u_phase (
    .clk             (clk),
    .reset           (reset),
    .weight_bitwidth (weight_bitwidth),
    .phase           (w_phase),
    .last_phase      (w_last)
  );
  assign w_hold = hold_cycles(weight_bitwidth);
  // Read one cycle before the last phase so the capture lands on the 1->0 / 3->0 boundary
  assign w_align = w_hold == 3'd1 || (w_hold == 3'd2 ? w_phase == 2'd0 : w_phase == 2'd2);
  assign w_rd = (r_state == S_WAIT_ALIGN || r_state == S_STREAM) && r_rd_cnt != r_num && w_align;
  assign mem_rd_en = w_rd;
  assign mem_addr = w_rd ? r_base + ADDR_W'(r_rd_cnt) : '0;
  assign buffer_out = r_buf;
  assign out_valid = r_valid && (r_state == S_STREAM || r_state == S_FLUSH);
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_num     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_valid   <= 1'b0;
      r_buf     <= '0;
    end else begin
      r_rd_pend <= w_rd;
      if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_rd_pend) begin
        r_buf    <= mem_rdata;
        r_wr_cnt <= r_wr_cnt + 1'b1;
        r_valid  <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_base   <= base_addr;
            r_num    <= num_words;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_state  <= num_words == '0 ? S_DONE : S_WAIT_ALIGN;
          end
        end
        S_WAIT_ALIGN: if (w_rd) r_state <= S_STREAM;
        S_STREAM:     if (r_rd_cnt == r_num) r_state <= S_FLUSH;
        S_FLUSH:      if (r_wr_cnt == r_num && w_last) r_state <= S_DONE;
        default:      r_state <= S_IDLE;
      endcase
    end
endmodule
